// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC/IR fetch stage over a synchronous ROM with relative branches.
// Define FETCH_HALT_DETECT_EN to stop fetching and raise Halted on HALT_WORD.
module instr_fetch_unit #(
    parameter int PC_W = 7,
    parameter int IR_W = 16,
    parameter logic [IR_W-1:0] HALT_WORD = 16'h5000
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            FetchReq,
    input  logic            BranchEn,
    input  logic [7:0]      BranchOff,
    output logic [PC_W-1:0] RomAddr,
    input  logic [IR_W-1:0] RomData,
    output logic [PC_W-1:0] PC_Out,
    output logic [IR_W-1:0] IR_Out,
    output logic            IrValid,
    output logic            Busy,
    output logic            Halted
);
`ifdef FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, READ, HALT} state_t;

    state_t          state, state_n;
    logic [PC_W-1:0] off, target;

    // Sized signed cast sign-extends or truncates the offset to PC width.
    assign off     = PC_W'($signed(BranchOff));
    assign target  = BranchEn ? PC_Out + off : PC_Out;
    assign RomAddr = (state == IDLE) ? target : PC_Out;
    assign Busy    = (state == READ);
    assign Halted  = (state == HALT);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = FetchReq ? READ : IDLE;
            READ:    state_n = (HALT_EN && RomData == HALT_WORD) ? HALT : IDLE;
            default: state_n = HALT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            PC_Out  <= '0;
            IR_Out  <= '0;
            IrValid <= 1'b0;
        end else begin
            state   <= state_n;
            IrValid <= (state == READ);
            if (state == IDLE && (FetchReq || BranchEn))
                PC_Out <= target;
            if (state == READ) begin
                IR_Out <= RomData;
                PC_Out <= PC_Out + 1'b1;
            end
        end
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage sitting directly upstream of the processor controller: owns the 7-bit program counter and 16-bit instruction register, reads the synchronous instruction ROM, and hands each fetched instruction to the decode/execute state machine with a one-cycle valid pulse. It also applies PC-relative branches requested by the controller and stops fetching on the halt instruction 16'h5000.

## Interface
- PC_W, 7, program counter / ROM address width (128-word ROM)
- IR_W, 16, instruction width
- HALT_WORD, 16'h5000, halt instruction encoding
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high; one clock; one clock domain
- FetchReq  in  1  controller requests the next instruction; sampled only in IDLE
- BranchEn  in  1  apply relative branch; sampled only in IDLE
- BranchOff  in  8  signed two's-complement branch offset
- RomAddr  out  PC_W  instruction ROM address (combinational)
- RomData  in  IR_W  instruction ROM read data, valid one cycle after RomAddr is sampled
- PC_Out  out  PC_W  program counter (address of next instruction to fetch)
- IR_Out  out  IR_W  instruction register
- IrValid  out  1  one-cycle pulse: IR_Out holds a newly fetched instruction
- Busy  out  1  high while a ROM read is in flight
- Halted  out  1  sticky: halt instruction fetched

## Operation
- States: IDLE, READ, HALT. Reset -> IDLE.
- Reset values: PC_Out=0, IR_Out=0, IrValid=0, Busy=0, Halted=0.
- Target = BranchEn ? PC + sext(BranchOff) : PC, all mod 2^PC_W (wraps both directions). RomAddr = Target in IDLE, PC in READ/HALT.
- IDLE, BranchEn=1, FetchReq=0: PC <= Target; stay IDLE.
- IDLE, FetchReq=1: PC <= Target (branch and fetch together fetch from the branch target); -> READ.
- READ: IR_Out <= RomData; PC <= PC+1 (127 wraps to 0); IrValid <= 1; -> IDLE, or -> HALT if RomData == HALT_WORD. FetchReq/BranchEn ignored.
- HALT: PC, IR frozen; Halted=1; FetchReq/BranchEn ignored; exit only via Reset.
- Busy = (state == READ).
- Reset in any state, including mid-READ: in-flight read discarded, all outputs to reset values next cycle, no IrValid pulse.

## Timing
- FetchReq sampled at edge k (IDLE); ROM samples RomAddr at edge k; READ during cycle k..k+1; IR_Out, PC_Out update and IrValid rises at edge k+1; IrValid falls at edge k+2.
- Fetch latency: 2 edges request-to-IrValid; max throughput one instruction per 2 cycles (FetchReq held high refetches immediately on return to IDLE).
- Branch-only: PC_Out updates at the next edge, no IrValid.
- Halted rises at the same edge as the IrValid pulse for the halt word; IrValid still pulses once for it.

## Configuration
- FETCH_HALT_DETECT_EN defined: HALT state and Halted output as above.
- Not defined: no HALT state; HALT_WORD is loaded like any other instruction and fetch continues; Halted tied 0.

## Test plan
- Reset then FetchReq pulse with ROM[0]=16'h1234 -> RomAddr=0 at request, IR_Out=16'h1234, PC_Out=1, IrValid high exactly one cycle, 2 edges after request.
- FetchReq held high over ROM[0..2]=16'h0001,16'h0002,16'h0003 -> three IrValid pulses every other cycle, PC_Out=3, Busy alternates.
- PC=10, BranchEn=1, BranchOff=8'hFB (-5), FetchReq=1, ROM[5]=16'hABCD -> RomAddr=5, IR_Out=16'hABCD, PC_Out=6; repeat from PC=126 with offset +3 -> RomAddr=1 (wrap).
- Fetch at PC=127 -> PC_Out=0 after load; FetchReq/BranchEn asserted during READ -> no effect.
- ROM[4]=16'h5000 with macro defined -> IrValid one pulse, Halted=1, IR_Out=16'h5000, PC_Out=5 frozen despite further FetchReq; Reset -> all zero. Without macro -> Halted=0 and next FetchReq fetches ROM[5].
- Reset asserted during READ -> next cycle IR_Out=0, PC_Out=0, IrValid=0, Busy=0, state IDLE.
